// File: rtl/alu_share_pkg.sv
// Shared types and constants for the alu_share_sched block.
package alu_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/alu_share_sched_rr_arbiter.sv
// Rotating-priority arbiter: the requester just after 'last' has top priority.
// Purely combinational; grant is only meaningful when any_req is high.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [IDW-1:0]  grant,
  output logic            any_req
);

  // Walk candidates from farthest to nearest so the nearest hit after 'last' wins.
  always_comb begin
    logic [IDW-1:0] idx;
    idx     = '0;
    grant   = '0;
    any_req = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDW'((int'(last) + k) % NREQ);
      if (req[idx]) begin
        grant   = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_sched.sv
// Shared add/sub unit serving NREQ requesters with round-robin arbitration.
// Each operation runs IDLE (accept) -> EXEC (compute) -> RESP (hold result).
// Optional feature macro ALU_SHARE_FLAGS_EN adds rsp_flag (carry on add,
// borrow on subtract), registered together with rsp_data.
//
// state | meaning
// IDLE  | waiting for a request; grants one and captures its operands
// EXEC  | computes the result into rsp_data/rsp_id
// RESP  | rsp_valid high until the consumer accepts
module alu_share_sched
  import alu_share_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_op,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
`ifdef ALU_SHARE_FLAGS_EN
  output logic                  rsp_flag,
`endif
  output logic                  busy
);

  state_t           state, state_next;
  logic [IDW-1:0]   last;
  logic [IDW-1:0]   grant;
  logic             any_req;
  logic             take;
  logic             op_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic [IDW-1:0]   id_r;
  logic [WIDTH-1:0] alu_res;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req_valid),
    .last    (last),
    .grant   (grant),
    .any_req (any_req)
  );

`ifdef ALU_SHARE_FLAGS_EN
  logic [WIDTH:0] alu_full;

  // One extra bit: carry-out on add, borrow (a < b) on subtract.
  always_comb begin
    alu_full = (op_r == OP_SUB) ? ({1'b0, a_r} - {1'b0, b_r})
                                : ({1'b0, a_r} + {1'b0, b_r});
  end

  assign alu_res = alu_full[WIDTH-1:0];
`else
  // Plain WIDTH-bit add/sub, wrapping mod 2^WIDTH.
  always_comb begin
    alu_res = (op_r == OP_SUB) ? (a_r - b_r) : (a_r + b_r);
  end
`endif

  // Next-state and handshake outputs; ready only ever asserted in IDLE.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    take       = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          req_ready[grant] = 1'b1;
          take             = 1'b1;
          state_next       = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // State, pointer, operand capture and result registers; pointer moves only on response handshake.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= IDLE;
      last     <= IDW'(NREQ - 1);
      op_r     <= OP_ADD;
      a_r      <= '0;
      b_r      <= '0;
      id_r     <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
`ifdef ALU_SHARE_FLAGS_EN
      rsp_flag <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (take) begin
        op_r <= req_op[grant];
        a_r  <= req_a[int'(grant)*WIDTH +: WIDTH];
        b_r  <= req_b[int'(grant)*WIDTH +: WIDTH];
        id_r <= grant;
      end
      if (state == EXEC) begin
        rsp_data <= alu_res;
        rsp_id   <= id_r;
`ifdef ALU_SHARE_FLAGS_EN
        rsp_flag <= alu_full[WIDTH];
`endif
      end
      if (rsp_valid && rsp_ready) last <= id_r;
    end
  end

endmodule
